// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, a 1-entry skid buffer behind stall, and the IF/ID register.
// Optional HALT detection is compiled in with `define FETCH_HALT_DETECT_EN.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_id_valid,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic [4:0]  if_id_opcode,
    output logic        halted
);

`ifdef FETCH_HALT_DETECT_EN
    localparam logic [4:0] HALT_OPCODE = 5'h1F;
`endif

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALTED} state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic        drop, drop_n;
    logic [15:0] buf_q, buf_n;
    logic        v_n;
    logic [15:0] instr_n, ipc_n;
    logic        load;
    logic [15:0] load_word;

    assign imem_req     = (state == S_FETCH);
    assign imem_addr    = pc;
    assign if_id_opcode = if_id_instr[15:11];

`ifdef FETCH_HALT_DETECT_EN
    assign halted = (state == S_HALTED);
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        drop_n    = drop;
        buf_n     = buf_q;
        v_n       = if_id_valid;
        instr_n   = if_id_instr;
        ipc_n     = if_id_pc;
        load      = 1'b0;
        load_word = '0;
        if (redirect) begin
            // a request still in flight must have its response thrown away
            pc_n    = redirect_pc;
            v_n     = 1'b0;
            buf_n   = '0;
            state_n = S_FETCH;
            drop_n  = (state == S_FETCH) && !imem_valid;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (imem_valid && drop) begin
                        drop_n = 1'b0;
                        if (!stall) v_n = 1'b0;
                    end else if (imem_valid && stall) begin
                        buf_n   = imem_rdata;
                        state_n = S_HOLD;
                    end else if (imem_valid) begin
                        load      = 1'b1;
                        load_word = imem_rdata;
                    end else if (!stall) begin
                        v_n = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        load      = 1'b1;
                        load_word = buf_q;
                        buf_n     = '0;
                        state_n   = S_FETCH;
                    end
                end
                S_HALTED: begin
                    if (!stall) v_n = 1'b0;
                end
                default: state_n = S_FETCH;
            endcase
            if (load) begin
                v_n     = 1'b1;
                instr_n = load_word;
                ipc_n   = pc;
                pc_n    = pc + 16'd1;
`ifdef FETCH_HALT_DETECT_EN
                if (load_word[15:11] == HALT_OPCODE) state_n = S_HALTED;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            buf_q       <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            drop        <= drop_n;
            buf_q       <= buf_n;
            if_id_valid <= v_n;
            if_id_instr <= instr_n;
            if_id_pc    <= ipc_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect/latency traffic,
// checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [4:0]  if_id_opcode;
    logic        halted;

    localparam logic [4:0] HALT_OP = 5'h1F;
`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_opcode(if_id_opcode),
        .halted(halted)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // model: fetch pointer, pending-discard flag, parked word, halt flag, IF/ID contents
    logic [15:0] m_pc, m_buf, m_instr, m_ipc;
    bit          m_drop, m_pend, m_halt, m_v;
    // memory environment
    bit          mb_busy;
    int          mb_rem;
    logic [15:0] mb_addr;
    int          lat_mode;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        logic [15:0] d;
        case (a)
            16'h0000: d = 16'h0800;
            16'h0001: d = 16'h1234;
            16'h0010: d = 16'hF800;
            default: begin
                d = (a * 16'h9E37) ^ 16'h3C5A;
                if (d[15:11] == HALT_OP) d[15] = 1'b0;
            end
        endcase
        return d;
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_buf = '0; m_instr = '0; m_ipc = '0;
        m_drop = 0; m_pend = 0; m_halt = 0; m_v = 0;
        mb_busy = 0; mb_rem = 0; mb_addr = '0;
    endtask

    task automatic compare_outputs();
        bit exp_req;
        exp_req = !m_pend && !m_halt;
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("if_id_valid", if_id_valid, m_v);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc", if_id_pc, m_ipc);
        chk("if_id_opcode", if_id_opcode, m_instr[15:11]);
        chk("halted", halted, m_halt);
    endtask

    // advance the model by one clock given the inputs applied this cycle
    task automatic model_step();
        bit          req_now, have, from_mem;
        logic [15:0] w;
        req_now = !m_pend && !m_halt;
        if (redirect) begin
            m_pc = redirect_pc; m_v = 0; m_pend = 0; m_halt = 0;
            m_drop = req_now && !imem_valid;
            return;
        end
        have = 0; from_mem = 0; w = '0;
        if (req_now && imem_valid) begin
            if (m_drop) m_drop = 0;
            else begin have = 1; w = imem_rdata; from_mem = 1; end
        end else if (m_pend) begin
            have = 1; w = m_buf;
        end
        if (!have) begin
            if (!stall) m_v = 0;
        end else if (stall) begin
            if (from_mem) begin m_pend = 1; m_buf = w; end
        end else begin
            m_v = 1; m_instr = w; m_ipc = m_pc; m_pc = m_pc + 16'd1; m_pend = 0;
            if (HALT_EN && w[15:11] == HALT_OP) m_halt = 1;
        end
    endtask

    // one cycle: check outputs, run memory, apply inputs, step the model
    task automatic cyc(input bit st, input bit rd, input logic [15:0] rpc);
        @(negedge clk);
        compare_outputs();
        imem_valid = 1'b0;
        imem_rdata = 16'($urandom);
        if (mb_busy) begin
            if (mb_rem == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_fn(mb_addr);
                mb_busy = 0;
            end else mb_rem--;
        end else if (imem_req) begin
            mb_busy = 1;
            mb_addr = imem_addr;
            mb_rem = ((lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode) - 1;
        end
        stall = st; redirect = rd; redirect_pc = rpc;
        model_step();
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // reset with a stray response strobe on the bus, which must be ignored
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_valid = 1'b1; imem_rdata = 16'hBEEF;
        stall = 0; redirect = 0;
        #1;
        model_reset();
        compare_outputs();
        repeat (2) @(negedge clk);
        imem_valid = 1'b0;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        stall = 0; redirect = 0; redirect_pc = '0; imem_valid = 0; imem_rdata = '0;
        lat_mode = 1;
        model_reset();
        apply_reset();
        chk("rst_req", imem_req, 1'b1);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", if_id_valid, 1'b0);
        chk("rst_instr", if_id_instr, 16'h0000);
        chk("rst_halted", halted, 1'b0);

        // first fetch at 1-cycle latency
        cyc(0, 0, 0); cyc(0, 0, 0); settle();
        chk("r31_pc", if_id_pc, 16'h0000);
        chk("r31_instr", if_id_instr, 16'h0800);
        chk("r31_opcode", if_id_opcode, 5'h01);
        chk("r31_valid", if_id_valid, 1'b1);
        chk("r31_next_addr", imem_addr, 16'h0001);

        // response arrives under stall, gets parked, then released
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0); settle();
        chk("r32_hold_req", imem_req, 1'b0);
        chk("r32_hold_instr", if_id_instr, 16'h0800);
        cyc(0, 0, 0); settle();
        chk("r32_instr", if_id_instr, 16'h1234);
        chk("r32_pc", if_id_pc, 16'h0001);
        chk("r32_next_addr", imem_addr, 16'h0002);

        // redirect while a 3-cycle request is outstanding
        lat_mode = 3;
        cyc(0, 0, 0); cyc(0, 1, 16'h0040); settle();
        chk("r33_valid", if_id_valid, 1'b0);
        chk("r33_addr", imem_addr, 16'h0040);
        cyc(0, 0, 0); cyc(0, 0, 0); settle();
        chk("r33_drop_valid", if_id_valid, 1'b0);
        chk("r33_drop_addr", imem_addr, 16'h0040);
        lat_mode = 1;
        cyc(0, 0, 0); cyc(0, 0, 0); settle();
        chk("r33_pc", if_id_pc, 16'h0040);
        chk("r33_instr", if_id_instr, mem_fn(16'h0040));

        // redirect coinciding with the response
        cyc(0, 0, 0); cyc(0, 1, 16'h0100); settle();
        chk("r34_valid", if_id_valid, 1'b0);
        chk("r34_addr", imem_addr, 16'h0100);
        cyc(0, 0, 0); cyc(0, 0, 0); settle();
        chk("r34_pc", if_id_pc, 16'h0100);
        chk("r34_vld", if_id_valid, 1'b1);

        // wrap from 0xFFFF
        cyc(0, 1, 16'hFFFF); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); settle();
        chk("r36_pc", if_id_pc, 16'hFFFF);
        chk("r36_addr", imem_addr, 16'h0000);
        chk("r36_model_pc", m_pc, 16'h0000);

        // HALT word at 0x0010
        cyc(0, 1, 16'h0010); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); settle();
        chk("r35_pc", if_id_pc, 16'h0010);
        chk("r35_model_pc", m_pc, 16'h0011);
`ifdef FETCH_HALT_DETECT_EN
        chk("r35_halted", halted, 1'b1);
        chk("r35_req", imem_req, 1'b0);
`else
        chk("r35_halted", halted, 1'b0);
        chk("r35_req", imem_req, 1'b1);
        chk("r35_addr", imem_addr, 16'h0011);
`endif
        cyc(0, 1, 16'h0000); settle();
        chk("r35_resume_halted", halted, 1'b0);
        chk("r35_resume_req", imem_req, 1'b1);
        chk("r35_resume_addr", imem_addr, 16'h0000);

        // reset in the middle of a request
        lat_mode = 3;
        cyc(0, 0, 0); cyc(0, 0, 0);
        apply_reset();
        chk("r27_req", imem_req, 1'b1);
        chk("r27_addr", imem_addr, 16'h0000);
        chk("r27_valid", if_id_valid, 1'b0);
        repeat (6) cyc(0, 0, 0);

        // randomized traffic
        lat_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            bit          st, rd;
            logic [15:0] rpc;
            st = ($urandom % 10) < 3;
            rd = ($urandom % 20) == 0;
            rpc = (($urandom % 4) == 0) ? (16'hFFFE + 16'($urandom % 3)) : 16'($urandom);
            cyc(st, rd, rpc);
        end
        @(negedge clk);
        compare_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
